// File: rtl/k_wr_arb_t1.sv
// k_wr_arb_t1: round-robin arbiter sharing the single async-FIFO write port
// among nreq requesters in the wclk domain. A granted requester owns the port
// for a burst of at most max_burst words; no write is issued while wfull=1.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; scan req from rr_ptr and pick the next owner
// S_BURST | owner holds the port; one word per cycle when req & ~wfull
module k_wr_arb_t1 #(
    parameter int nreq      = 4,
    parameter int dsize     = 8,
    parameter int max_burst = 4,
    localparam int ow_w     = $clog2(nreq),
    localparam int bc_w     = $clog2(max_burst + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*dsize-1:0] req_data,
    input  logic                  wfull,
    output logic [nreq-1:0]       gnt,
    output logic                  winc,
    output logic [dsize-1:0]      wdata,
    output logic                  busy,
    output logic [ow_w-1:0]       owner
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          state, state_nxt;
    logic [ow_w-1:0] owner_nxt;
    logic [ow_w-1:0] rr_ptr, rr_nxt;
    logic [bc_w-1:0] bcnt, bcnt_nxt;

    logic            found;
    logic [ow_w-1:0] pick;
    logic            req_own;
    logic            accept;

    // Round-robin scan: first requester at or after rr_ptr, wrapping modulo nreq.
    always_comb begin
        logic [ow_w:0] cand;
        found = 1'b0;
        pick  = owner;
        cand  = '0;
        for (int k = 0; k < nreq; k++) begin
            cand = {1'b0, rr_ptr} + (ow_w + 1)'(k);
            if (cand >= (ow_w + 1)'(nreq))
                cand = cand - (ow_w + 1)'(nreq);
            if (!found && req[cand[ow_w-1:0]]) begin
                found = 1'b1;
                pick  = cand[ow_w-1:0];
            end
        end
    end

    // Owner's request and data slice; wdata follows the owner in every state.
    always_comb begin
        req_own = 1'b0;
        wdata   = req_data[dsize-1:0];
        for (int i = 0; i < nreq; i++) begin
            if (owner == ow_w'(i)) begin
                req_own = req[i];
                wdata   = req_data[i*dsize +: dsize];
            end
        end
    end

    // Next-state logic: arbitration in IDLE, burst accounting and release in BURST.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        bcnt_nxt  = bcnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    bcnt_nxt  = '0;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                accept = req_own & ~wfull;
                // A dropped request releases without writing; the last word of
                // a full burst releases on its accept. A wfull stall holds all.
                if (!req_own || (accept && bcnt == bc_w'(max_burst - 1))) begin
                    state_nxt = S_IDLE;
                    rr_nxt    = (owner == ow_w'(nreq - 1)) ? '0 : owner + 1'b1;
                    bcnt_nxt  = '0;
                end else if (accept) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write strobes decoded from the accept; reset clears state so these drop at once.
    always_comb begin
        gnt  = '0;
        winc = accept;
        busy = (state == S_BURST);
        for (int i = 0; i < nreq; i++)
            gnt[i] = accept && (owner == ow_w'(i));
    end

    // Registered arbiter state.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= S_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            bcnt   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            bcnt   <= bcnt_nxt;
        end
    end

endmodule
